// File: rtl/bcd_updown_counter.sv
// Packed-BCD up/down counter stepped by rising edges of an asynchronous tick level (DIGITS x 4 bits).
// Latency: tick_in high before clk edge N -> count/wrap/step_o update at edge N+2.
// No backpressure: steps are never queued; a step while en=0 or colliding with clr/load is lost.
// Optional build macro BCD_SATURATE_EN: hold at the all-9s/all-0s limit instead of wrapping.
module bcd_updown_counter #(
    parameter int                    DIGITS   = 4,
    parameter logic [4*DIGITS-1:0]   INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic                  step_o
);

    localparam int W = 4 * DIGITS;

    // Synchroniser pair (s1, s2) plus one edge-history flop (s3).
    logic s1;
    logic s2;
    logic s3;
    logic step;

    logic [W-1:0] count_nxt;
    logic         wrap_nxt;
    logic [W:0]   inc_res;   // {carry out of the MSD, incremented value}
    logic [W:0]   dec_res;   // {borrow out of the MSD, decremented value}

    // Increment by one with a carry ripple through all digits in one cycle.
    function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        logic [3:0]   d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (d >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Decrement by one with a borrow ripple through all digits in one cycle.
    function automatic logic [W:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        logic [3:0]   d;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (b) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    b           = 1'b1;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return {b, r};
    endfunction

    // Any non-decimal digit in a load value becomes 0 so count stays valid BCD.
    function automatic logic [W-1:0] bcd_clean(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd0;
            end
        end
        return r;
    endfunction

    // Bring tick_in into the clk domain and keep one cycle of history for edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // One strobe per synchronised rising edge of tick_in.
    assign step = s2 & ~s3;

    assign inc_res = bcd_inc(count);
    assign dec_res = bcd_dec(count);

    // Next-count selection: clr beats load beats an enabled step.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (clr) begin
            count_nxt = INIT_VAL;
        end else if (load) begin
            count_nxt = bcd_clean(load_val);
        end else if (step && en) begin
`ifdef BCD_SATURATE_EN
            // At the limit the count holds and wrap doubles as a limit flag.
            if (up_dn) begin
                count_nxt = inc_res[W] ? count : inc_res[W-1:0];
                wrap_nxt  = inc_res[W];
            end else begin
                count_nxt = dec_res[W] ? count : dec_res[W-1:0];
                wrap_nxt  = dec_res[W];
            end
`else
            if (up_dn) begin
                count_nxt = inc_res[W-1:0];
                wrap_nxt  = inc_res[W];
            end else begin
                count_nxt = dec_res[W-1:0];
                wrap_nxt  = dec_res[W];
            end
`endif
        end
    end

    // Register the count and both single-cycle strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= INIT_VAL;
            wrap   <= 1'b0;
            step_o <= 1'b0;
        end else begin
            count  <= count_nxt;
            wrap   <= wrap_nxt;
            step_o <= step;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 10000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick_in = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         wrap;
    logic         step_o;

    int errors = 0;
    int checks = 0;
    int model_val = 0;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         wrp;
    } exp_t;
    exp_t sb[$];

    bcd_updown_counter #(.DIGITS(DIGITS), .INIT_VAL('0)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .count(count), .wrap(wrap), .step_o(step_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one step and queue the expected output.
    task automatic push_step();
        exp_t e;
        e.wrp = 1'b0;
        if (en) begin
            if (up_dn) begin
                if (model_val == MODV - 1) begin
                    e.wrp = 1'b1;
`ifndef BCD_SATURATE_EN
                    model_val = 0;
`endif
                end else begin
                    model_val = model_val + 1;
                end
            end else begin
                if (model_val == 0) begin
                    e.wrp = 1'b1;
`ifndef BCD_SATURATE_EN
                    model_val = MODV - 1;
`endif
                end else begin
                    model_val = model_val - 1;
                end
            end
        end
        e.cnt = to_bcd(model_val);
        sb.push_back(e);
    endtask

    // Wait (bounded) for the step strobe, then pop and compare.
    task automatic wait_step(input string tag);
        int n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!step_o) check({tag, "_nowrap_idle"}, {31'd0, wrap}, 32'd0);
        end while (!step_o && n < 10);
        check({tag, "_step_seen"}, {31'd0, step_o}, 32'd1);
        check({tag, "_latency"}, n, 32'd3);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_count"}, {16'd0, count}, {16'd0, e.cnt});
            check({tag, "_wrap"}, {31'd0, wrap}, {31'd0, e.wrp});
        end
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        tick_in = 1'b1;
        push_step();
        wait_step(tag);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [W-1:0] held;

        // 1: reset, then idle
        repeat (2) @(negedge clk);
        check("rst_count", {16'd0, count}, 32'd0);
        check("rst_wrap", {31'd0, wrap}, 32'd0);
        check("rst_step", {31'd0, step_o}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_count", {16'd0, count}, 32'd0);
            check("idle_wrap", {31'd0, wrap}, 32'd0);
            check("idle_step", {31'd0, step_o}, 32'd0);
        end

        // 2: twelve up steps
        en = 1'b1;
        up_dn = 1'b1;
        for (int i = 0; i < 12; i++) tick("up12");
        check("up12_final", {16'd0, count}, 32'h0012);

        // 3: wrap (or saturate) at the top
        do_load(16'h9998);
        model_val = 9998;
        check("load9998", {16'd0, count}, 32'h9998);
        check("load_nowrap", {31'd0, wrap}, 32'd0);
        for (int i = 0; i < 3; i++) tick("top");

        // 4: down wrap at zero, borrow ripple, invalid digits on load
        do_load(16'h0000);
        model_val = 0;
        up_dn = 1'b0;
        tick("down0");
        do_load(16'h1000);
        model_val = 1000;
        tick("borrow");
        check("borrow_val", {16'd0, count}, 32'h0999);
        do_load(16'h00A3);
        model_val = 3;
        check("load_bad_digit", {16'd0, count}, 32'h0003);
        do_load(16'hFB7C);
        model_val = 70;
        check("load_bad_multi", {16'd0, count}, 32'h0070);
        up_dn = 1'b1;
        tick("up_after_load");

        // 5: clr + load + step collide; then load + step
        do_load(16'h0055);
        @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1; load = 1'b1; load_val = 16'h4321;
        @(negedge clk);
        clr = 1'b0; load = 1'b0;
        check("clr_prio_count", {16'd0, count}, 32'h0000);
        check("clr_prio_wrap", {31'd0, wrap}, 32'd0);
        check("clr_prio_step_aligned", {31'd0, step_o}, 32'd1);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load = 1'b1; load_val = 16'h4321;
        @(negedge clk);
        load = 1'b0;
        check("load_prio_count", {16'd0, count}, 32'h4321);
        check("load_prio_step_aligned", {31'd0, step_o}, 32'd1);
        model_val = 4321;
        tick_in = 1'b0;
        repeat (3) @(negedge clk);

        // en=0 discards the step
        en = 1'b0;
        tick("en_off");
        repeat (5) @(negedge clk);
        check("en_off_hold", {16'd0, count}, 32'h4321);
        en = 1'b1;

        // 6: tick held high -> one step only
        @(negedge clk);
        tick_in = 1'b1;
        push_step();
        wait_step("held");
        held = count;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (step_o) pulses++;
        end
        check("held_no_more_steps", pulses, 32'd0);
        check("held_count", {16'd0, count}, {16'd0, held});

        // async reset mid-run with tick still high
        #1 rst = 1'b0;
        #1;
        check("async_rst_count", {16'd0, count}, 32'd0);
        check("async_rst_wrap", {31'd0, wrap}, 32'd0);
        check("async_rst_step", {31'd0, step_o}, 32'd0);
        model_val = 0;
        @(negedge clk);
        rst = 1'b1;
        push_step();
        wait_step("post_rst");
        tick_in = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
